// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master simpleBUS arbiter.
// State encodings double as the downstream mux select value.
// Master index constants and the default hold limit live here.
package bus_arbiter_pkg;

    // The state bit is driven straight onto m_sel, so GNT0 must be 0.
    typedef enum logic {
        GNT0 = 1'b0,
        GNT1 = 1'b1
    } state_t;

    localparam int M0               = 0;
    localparam int M1               = 1;
    localparam int DEFAULT_MAX_HOLD = 8;
    localparam int DEFAULT_HOLD_W   = 4;

endpackage

// File: rtl/bus_arbiter_hold_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; clear has priority over increment.
module hold_counter #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              inc,
    output logic [HOLD_W-1:0] cnt
);

    localparam logic [HOLD_W-1:0] CNT_MAX = {HOLD_W{1'b1}};

    logic [HOLD_W-1:0] cnt_d;
    logic [HOLD_W-1:0] cnt_q;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master simpleBUS arbiter driving registered one-hot grants and the 2:1 mux select.
// Latency: a request change sampled at edge N shows on the grants in cycle N+1.
// Backpressure: owner holds until it drops its request; ARB_TIMEOUT_EN adds a forced handover.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int HOLD_W   = DEFAULT_HOLD_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_grant,
    output logic m1_grant,
    output logic m_sel,
    output logic handover
);

    state_t            state_d;
    state_t            state_q;
    logic              handover_d;
    logic              handover_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        req_vec;
    logic              owner_req;
    logic              other_req;
    logic              switch_now;

    // Request vector indexed by master number so the owner lookup follows the state bit.
    always_comb begin
        req_vec     = '0;
        req_vec[M0] = m0_req;
        req_vec[M1] = m1_req;
        owner_req   = req_vec[state_q];
        other_req   = req_vec[~state_q];
    end

    // Next owner: hold while requesting, otherwise hand to the other requester or park on M0.
    always_comb begin
        state_d    = state_q;
        switch_now = 1'b0;
        case (state_q)
            GNT0: begin
                if (!m0_req && m1_req) begin
                    state_d = GNT1;
                end
            end
            GNT1: begin
                if (!m1_req) begin
                    state_d = GNT0;
                end
            end
            default: state_d = GNT0;
        endcase
`ifdef ARB_TIMEOUT_EN
        // Under contention the owner loses the bus after MAX_HOLD owned cycles.
        if (owner_req && other_req && (hold_cnt == HOLD_W'(MAX_HOLD - 1))) begin
            state_d = (state_q == GNT0) ? GNT1 : GNT0;
        end
`endif
        switch_now = (state_d != state_q);
        handover_d = switch_now;
    end

`ifndef ARB_TIMEOUT_EN
    // Without the forced handover the hold count has no consumer.
    logic unused_hold;
    assign unused_hold = ^hold_cnt;
`endif

    // State and handover pulse registers; reset parks ownership on M0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= GNT0;
            handover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            handover_q <= handover_d;
        end
    end

    hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_hold_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (switch_now),
        .inc     (owner_req),
        .cnt     (hold_cnt)
    );

    assign m0_grant = (state_q == GNT0);
    assign m1_grant = (state_q == GNT1);
    assign m_sel    = state_q;
    assign handover = handover_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scoreboard of expected {m0_grant,m1_grant,m_sel,handover}.
// Expectations are pushed when requests are driven and popped after the sampling edge.
// Compile with +define+ARB_TIMEOUT_EN to exercise the forced handover (MAX_HOLD=3).
module tb_bus_arbiter;

    localparam int TB_MAX_HOLD = 3;

    logic clk;
    logic reset_n;
    logic m0_req;
    logic m1_req;
    logic m0_grant;
    logic m1_grant;
    logic m_sel;
    logic handover;

    logic [3:0] sb[$];
    int         n_checks;
    int         n_pass;

    bus_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .HOLD_W   (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_grant (m0_grant),
        .m1_grant (m1_grant),
        .m_sel    (m_sel),
        .handover (handover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply requests at the falling edge, record the expectation, move #1 past the next rising edge.
    task automatic drive(input logic r0, input logic r1, input logic [3:0] e);
        @(negedge clk);
        m0_req = r0;
        m1_req = r1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        logic [3:0] obs;
        reset_n = 1'b0;
        m0_req  = 1'b1;
        m1_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(4'b1000);
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {m0_grant, m1_grant, m_sel, handover};
            n_checks++;
            if (obs !== e) $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, e);
            else n_pass++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 4'b1000);
        e   = sb.pop_front();
        obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL reset_release: got %b expected %b", obs, e);
        else n_pass++;
    endtask

    task automatic test_simple_switch();
        logic [3:0] e;
        logic [3:0] obs;
        drive(1'b0, 1'b1, 4'b0111);
        drive(1'b0, 1'b1, 4'b0110);
        drive(1'b0, 1'b0, 4'b1001);
        drive(1'b0, 1'b0, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
        end
        // Re-run one step at a time so each observation lines up with its expectation.
        drive(1'b0, 1'b1, 4'b0111);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL switch_to_m1: got %b expected %b", obs, e);
        else n_pass++;
        drive(1'b0, 1'b1, 4'b0110);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL switch_pulse_end: got %b expected %b", obs, e);
        else n_pass++;
        drive(1'b0, 1'b0, 4'b1001);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL switch_back_m0: got %b expected %b", obs, e);
        else n_pass++;
        drive(1'b0, 1'b0, 4'b1000);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL switch_settle: got %b expected %b", obs, e);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [3:0] e;
        logic [3:0] obs;
        logic       own1;
        logic       ho;
        // Parked on M0 with a cleared hold count; cycle k follows the k-th contended edge.
        for (int k = 1; k <= 20; k++) begin
`ifdef ARB_TIMEOUT_EN
            own1 = ((k / TB_MAX_HOLD) % 2) == 1;
            ho   = (k % TB_MAX_HOLD) == 0;
`else
            own1 = 1'b0;
            ho   = 1'b0;
`endif
            drive(1'b1, 1'b1, {~own1, own1, own1, ho});
            e   = sb.pop_front();
            obs = {m0_grant, m1_grant, m_sel, handover};
            n_checks++;
            if (obs !== e) $display("FAIL contention[%0d]: got %b expected %b", k, obs, e);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 4'b1000);
        e   = sb.pop_front();
        obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL contention_release: got %b expected %b", obs, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        logic [3:0] obs;
        logic [1:0] reqs[5];
        logic [3:0] exps[5];
        reqs = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
        exps = '{4'b1000, 4'b0111, 4'b0110, 4'b1001, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            drive(reqs[i][1], reqs[i][0], exps[i]);
            e   = sb.pop_front();
            obs = {m0_grant, m1_grant, m_sel, handover};
            n_checks++;
            if (obs !== e) $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        logic [3:0] obs;
        drive(1'b0, 1'b1, 4'b0111);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL arst_enter_m1: got %b expected %b", obs, e);
        else n_pass++;
        // Assert reset well away from any edge; grants must move before the next edge.
        #2;
        reset_n = 1'b0;
        sb.push_back(4'b1000);
        #1;
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL arst_immediate: got %b expected %b", obs, e);
        else n_pass++;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 4'b1000);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL arst_after_release: got %b expected %b", obs, e);
        else n_pass++;
        drive(1'b0, 1'b1, 4'b0111);
        e = sb.pop_front(); obs = {m0_grant, m1_grant, m_sel, handover};
        n_checks++;
        if (obs !== e) $display("FAIL arst_rerequest: got %b expected %b", obs, e);
        else n_pass++;
    endtask

    task automatic test_park();
        logic [3:0] e;
        logic [3:0] obs;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, (i == 0) ? 4'b1001 : 4'b1000);
            e   = sb.pop_front();
            obs = {m0_grant, m1_grant, m_sel, handover};
            n_checks++;
            if (obs !== e) $display("FAIL park[%0d]: got %b expected %b", i, obs, e);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        m0_req   = 1'b0;
        m1_req   = 1'b0;
        test_reset();
        test_simple_switch();
        test_contention();
        test_back_to_back();
        test_async_reset();
        test_park();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired at %0t", $time);
        $fatal(1);
    end

endmodule
